dmem_arbiter: RTL and testbench

- Two-requester arbiter that shares the single-port data memory (combinational read, write on posedge clk, word-addressed via a[31:2], 64 words) between the CPU data port (m0) and a loader/debug DMA port (m1).
- Round-robin arbitration with a bounded-burst ownership FSM, so one port can stream back-to-back accesses without starving the other.
- Read data is registered and returned one cycle after grant, with a valid strobe.
- Sits between the requesters and the data memory instance in the top level.

---
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (m0) and a DMA port (m1).
// Latency: grant is combinational in the request cycle; read data returns registered one cycle later.
// Backpressure: a requester holds req until gnt; under contention the owner gets at most MAX_BURST grants in a row.
module dmem_arbiter #(
    parameter int DEPTH     = 64,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wd,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wd,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    localparam logic [3:0]  MAXB    = 4'(MAX_BURST);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        last, last_nx;
    logic [3:0]  cnt_inc;
    logic        m0_inr, m1_inr;
    logic        rv0_q, rv1_q;
    logic [31:0] rd0_q, rd1_q;

    // Word index compared against the memory size; the byte offset bits are ignored.
    assign m0_inr  = {2'b00, m0_addr[31:2]} < DEPTH_W;
    assign m1_inr  = {2'b00, m1_addr[31:2]} < DEPTH_W;
    assign cnt_inc = (cnt >= MAXB) ? MAXB : cnt + 4'd1;

    // Ownership state: reset makes m0 win the first tie by pretending m1 was last.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            last  <= 1'b1;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            last  <= last_nx;
        end
    end

    // Grant decision and next ownership; no grant is ever issued while reset is high.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        last_nx  = last;
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last;
                        m1_gnt = !last;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
                OWN0: begin
                    if (m0_req && (!m1_req || cnt < MAXB)) m0_gnt = 1'b1;
                    else                                   m1_gnt = m1_req;
                end
                OWN1: begin
                    if (m1_req && (!m0_req || cnt < MAXB)) m1_gnt = 1'b1;
                    else                                   m0_gnt = m0_req;
                end
                default: ;
            endcase

            if (m0_gnt) begin
                state_nx = OWN0;
                last_nx  = 1'b0;
                cnt_nx   = (state == OWN0) ? cnt_inc : 4'd1;
            end else if (m1_gnt) begin
                state_nx = OWN1;
                last_nx  = 1'b1;
                cnt_nx   = (state == OWN1) ? cnt_inc : 4'd1;
            end else begin
                state_nx = IDLE;
                cnt_nx   = 4'd0;
            end
        end
    end

    // Memory drive: winner's request, out-of-range writes suppressed, all zero when idle.
    always_comb begin
        mem_we = 1'b0;
        mem_a  = 32'h0;
        mem_wd = 32'h0;
        if (m0_gnt) begin
            mem_we = m0_we && m0_inr;
            mem_a  = m0_addr;
            mem_wd = m0_wd;
        end else if (m1_gnt) begin
            mem_we = m1_we && m1_inr;
            mem_a  = m1_addr;
            mem_wd = m1_wd;
        end
    end

    // Read return: capture memory data for a granted read; out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            rv0_q <= 1'b0;
            rv1_q <= 1'b0;
            rd0_q <= 32'h0;
            rd1_q <= 32'h0;
        end else begin
            rv0_q <= m0_gnt && !m0_we;
            rv1_q <= m1_gnt && !m1_we;
            if (m0_gnt && !m0_we) rd0_q <= m0_inr ? mem_rd : 32'h0;
            if (m1_gnt && !m1_we) rd1_q <= m1_inr ? mem_rd : 32'h0;
        end
    end

    // A read granted just before reset must not surface while reset is asserted.
    assign m0_rvalid = rv0_q && !reset;
    assign m1_rvalid = rv1_q && !reset;
    assign m0_rdata  = reset ? 32'h0 : rd0_q;
    assign m1_rdata  = reset ? 32'h0 : rd1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int DEPTH = 64;
    localparam int MAXB  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wd = 0, m1_addr = 0, m1_wd = 0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Physical memory: aliases out-of-range addresses so the DUT must zero those reads itself.
    logic [31:0] mem [DEPTH];
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int          owner = -1;   // -1: nobody owns the memory
    int          run = 0;      // consecutive grants to owner, capped at MAXB
    int          last_g = 1;
    bit          pend [2];
    logic [31:0] pdat [2];
    logic [31:0] erd  [2];
    logic [31:0] sm   [DEPTH];

    always @(negedge clk) begin : model_chk
        bit          r [2];
        bit          w [2];
        logic [31:0] a [2];
        logic [31:0] d [2];
        int          g, o;
        bit          inr;
        r[0] = m0_req; r[1] = m1_req; w[0] = m0_we; w[1] = m1_we;
        a[0] = m0_addr; a[1] = m1_addr; d[0] = m0_wd; d[1] = m1_wd;
        if (reset) begin
            chk("rst_gnt0", m0_gnt, 0);   chk("rst_gnt1", m1_gnt, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_rv0", m0_rvalid, 0); chk("rst_rv1", m1_rvalid, 0);
            chk("rst_rd0", m0_rdata, 0);  chk("rst_rd1", m1_rdata, 0);
            owner = -1; run = 0; last_g = 1;
            pend[0] = 0; pend[1] = 0; erd[0] = 0; erd[1] = 0;
        end else begin
            g = -1;
            if (owner < 0) begin
                if (r[0] && r[1]) g = 1 - last_g;
                else if (r[0])    g = 0;
                else if (r[1])    g = 1;
            end else begin
                o = 1 - owner;
                if (r[owner] && (!r[o] || run < MAXB)) g = owner;
                else if (r[o])                         g = o;
            end
            chk("gnt0", m0_gnt, g == 0);
            chk("gnt1", m1_gnt, g == 1);
            inr = (g >= 0) && ((a[g] >> 2) < DEPTH);
            chk("mem_we", mem_we, (g >= 0) && w[g] && inr);
            chk("mem_a",  mem_a,  (g >= 0) ? a[g] : 32'h0);
            chk("mem_wd", mem_wd, (g >= 0) ? d[g] : 32'h0);
            for (int p = 0; p < 2; p++) begin
                if (pend[p]) erd[p] = pdat[p];
            end
            chk("rv0", m0_rvalid, pend[0]); chk("rd0", m0_rdata, erd[0]);
            chk("rv1", m1_rvalid, pend[1]); chk("rd1", m1_rdata, erd[1]);
            pend[0] = 0; pend[1] = 0;
            if (g >= 0) begin
                if (!w[g]) begin
                    pend[g] = 1;
                    pdat[g] = inr ? sm[a[g][7:2]] : 32'h0;
                end else if (inr) begin
                    sm[a[g][7:2]] = d[g];
                end
                run = (g == owner) ? ((run + 1 > MAXB) ? MAXB : run + 1) : 1;
                owner = g;
                last_g = g;
            end else begin
                owner = -1;
                run = 0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; m0_req = 0; m1_req = 0;
        adv();
        reset = 0;
    endtask

    task automatic new_txn(output logic rq, output logic we, output logic [31:0] a, output logic [31:0] d);
        rq = $urandom_range(0, 99) < 65;
        we = $urandom_range(0, 1) == 1;
        a  = $urandom_range(0, 79) << 2;
        d  = $urandom;
    endtask

    initial begin
        logic g0s, g1s;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 32'h0;
            sm[i]  = 32'h0;
        end
        mem[5] = 32'hDEADBEEF;
        sm[5]  = 32'hDEADBEEF;
        adv(); adv();
        reset = 0;

        // single read of word 5
        m0_req = 1; m0_we = 0; m0_addr = 32'h14;
        @(negedge clk); chk("t1_gnt", m0_gnt, 1); chk("t1_mem_a", mem_a, 32'h14);
        adv(); m0_req = 0;
        @(negedge clk);
        chk("t1_rvalid", m0_rvalid, 1); chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
        chk("t1_m1_rvalid", m1_rvalid, 0); chk("t1_m1_rdata", m1_rdata, 0);
        adv();

        // tie after reset goes to m0, then m1
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4;
        @(negedge clk); chk("tie_gnt0", m0_gnt, 1); chk("tie_gnt1", m1_gnt, 0);
        adv(); m0_req = 0;
        @(negedge clk); chk("tie_m1_gnt", m1_gnt, 1);
        adv(); m1_req = 0;
        adv();

        // burst cap under continuous contention: 0,0,0,0,1,1,1,1,0,0,0,0
        do_reset();
        m0_req = 1; m0_we = 0; m0_addr = 32'h8;
        m1_req = 1; m1_we = 0; m1_addr = 32'hC;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("burst_gnt0", m0_gnt, ((i / 4) % 2) == 0);
            chk("burst_onehot", m0_gnt ^ m1_gnt, 1);
            adv();
        end
        m0_req = 0; m1_req = 0;
        adv();

        // uncontended streaming writes by m1, then reads by m0
        for (int i = 0; i < 10; i++) begin
            m1_req = 1; m1_we = 1; m1_addr = i * 4; m1_wd = 32'h100 + i;
            @(negedge clk); chk("str_gnt", m1_gnt, 1); chk("str_we", mem_we, 1);
            adv();
        end
        m1_req = 0;
        for (int i = 0; i <= 10; i++) begin
            m0_req = (i < 10); m0_we = 0; m0_addr = i * 4;
            @(negedge clk);
            if (i < 10) chk("str_rd_gnt", m0_gnt, 1);
            if (i > 0) begin
                chk("str_rvalid", m0_rvalid, 1);
                chk("str_rdata", m0_rdata, 32'h100 + i - 1);
            end
            adv();
        end

        // out-of-range write dropped, read returns zero
        m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wd = 32'h12345678;
        @(negedge clk); chk("oor_wgnt", m0_gnt, 1); chk("oor_we", mem_we, 0);
        adv(); m0_we = 0;
        @(negedge clk); chk("oor_rgnt", m0_gnt, 1);
        adv(); m0_req = 0;
        @(negedge clk); chk("oor_rvalid", m0_rvalid, 1); chk("oor_rdata", m0_rdata, 32'h0);
        adv();

        // reset right after a granted read suppresses its return
        m1_req = 1; m1_we = 0; m1_addr = 32'h8;
        @(negedge clk); chk("mid_gnt", m1_gnt, 1);
        adv(); reset = 1; m1_req = 0;
        @(negedge clk); chk("mid_rvalid", m1_rvalid, 0);
        adv(); reset = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h4;
        @(negedge clk); chk("mid_first_m0", m0_gnt, 1);
        adv(); m0_req = 0; m1_req = 0;
        adv();

        // randomized traffic with held requests and occasional reset
        g0s = 1; g1s = 1;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!m0_req || g0s) new_txn(m0_req, m0_we, m0_addr, m0_wd);
            if (!m1_req || g1s) new_txn(m1_req, m1_we, m1_addr, m1_wd);
            @(negedge clk);
            g0s = m0_gnt; g1s = m1_gnt;
            adv();
        end
        reset = 0; m0_req = 0; m1_req = 0;
        adv(); adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
